fetch_stage: RTL

Instruction-fetch stage sitting directly downstream of the `PC` register. It issues `PCout` to a synchronous instruction memory (1-cycle read latency), pairs each returned instruction with its PC, and delivers them to the decode stage through the IF/ID pipeline register. It also supplies the sequential next-PC to the upstream PC mux. It honours the shared `hazrd` stall and a branch `flush`, and uses a one-entry skid buffer so no fetched instruction is lost or duplicated across a stall.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_skid.sv | 30 +++
 rtl/fetch_stage.sv | 97 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU widths, constants and the fetch payload type.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;

  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(2);
  localparam logic [DATA_W-1:0] NOP    = DATA_W'(16'h0000);

  // One fetched instruction tagged with its address.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  // Sequential successor of a PC; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_add(input logic [ADDR_W-1:0] pc);
    return ADDR_W'(pc + PC_INC);
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// Single-entry hold register that parks the in-flight fetch during a stall.
module fetch_skid
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         capture,
  input  logic         rel,
  input  fetch_entry_t cap_entry,
  output logic         hold_valid,
  output fetch_entry_t hold_entry
);

  // Clear beats capture; capture only fills an empty slot so a long stall keeps the first entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_entry <= '0;
    end else if (clear) begin
      hold_valid <= 1'b0;
    end else if (capture && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_entry <= cap_entry;
    end else if (rel) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues PC to a 1-cycle synchronous memory, pairs data with its
// PC and loads the IF/ID register, with a one-entry skid to survive stalls.
module fetch_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PCin,
  input  logic              hazrd,
  input  logic              flush,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pcNext,
  output logic              IFID_valid,
  output logic [ADDR_W-1:0] IFID_pc,
  output logic [ADDR_W-1:0] IFID_pcNext,
  output logic [DATA_W-1:0] IFID_instr
);

  logic              req_valid;
  logic [ADDR_W-1:0] req_pc;
  logic              hold_valid;
  fetch_entry_t      hold_entry;
  fetch_entry_t      req_entry_c;
  logic              skid_clear_c;
  logic              skid_capture_c;
  logic              skid_release_c;

  assign imem_addr = PCin;
  assign pcNext    = pc_add(PCin);

  // Skid controls follow the flush > stall > run priority.
  always_comb begin
    skid_clear_c      = 1'b0;
    skid_capture_c    = 1'b0;
    skid_release_c    = 1'b0;
    req_entry_c.pc    = req_pc;
    req_entry_c.instr = imem_rdata;
    if (flush) begin
      skid_clear_c = 1'b1;
    end else if (hazrd) begin
      skid_capture_c = req_valid;
    end else begin
      skid_release_c = hold_valid;
    end
  end

  fetch_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .clear      (skid_clear_c),
    .capture    (skid_capture_c),
    .rel        (skid_release_c),
    .cap_entry  (req_entry_c),
    .hold_valid (hold_valid),
    .hold_entry (hold_entry)
  );

  // Request tag and IF/ID register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid   <= 1'b0;
      req_pc      <= '0;
      IFID_valid  <= 1'b0;
      IFID_pc     <= '0;
      IFID_pcNext <= '0;
      IFID_instr  <= NOP;
    end else if (flush) begin
      req_valid  <= 1'b0;
      IFID_valid <= 1'b0;
      IFID_instr <= NOP;
    end else if (hazrd) begin
      // PCin is held upstream and re-issued once the stall lifts.
      req_valid <= 1'b0;
    end else begin
      if (hold_valid) begin
        IFID_valid  <= 1'b1;
        IFID_pc     <= hold_entry.pc;
        IFID_pcNext <= pc_add(hold_entry.pc);
        IFID_instr  <= hold_entry.instr;
      end else begin
        IFID_valid  <= req_valid;
        IFID_pc     <= req_pc;
        IFID_pcNext <= pc_add(req_pc);
        IFID_instr  <= req_valid ? imem_rdata : NOP;
      end
      req_valid <= 1'b1;
      req_pc    <= PCin;
    end
  end

  // A pending skid entry and a live request can never compete for IF/ID.
  a_no_skid_and_req : assert property (
    @(posedge clk) disable iff (rst) (!flush && !hazrd) |-> !(hold_valid && req_valid)
  );

endmodule
